// File: rtl/bp_trace_pkg.sv
// Shared trace-path widths and the serializer word-select encoding.
package bp_trace_pkg;

  localparam int trace_width_gp      = 64;
  localparam int trace_word_width_gp = 32;

  typedef enum logic {e_trace_lo, e_trace_hi} bp_trace_word_sel_e;

endpackage

// File: rtl/bp_trace_out_buffer_mem.sv
// 1R1W register array holding buffered trace packets: synchronous write, asynchronous read.
module bp_trace_out_buffer_mem
  import bp_trace_pkg::*;
#(
  parameter int els_p   = 16,
  parameter int width_p = trace_width_gp,
  localparam int addr_w_lp = $clog2(els_p)
) (
  input  logic                 i_clk,
  input  logic                 i_w_v,
  input  logic [addr_w_lp-1:0] i_w_addr,
  input  logic [width_p-1:0]   i_w_data,
  input  logic [addr_w_lp-1:0] i_r_addr,
  output logic [width_p-1:0]   o_r_data
);

  logic [width_p-1:0] r_mem [els_p];

  always_ff @(posedge i_clk) begin
    if (i_w_v) begin
      r_mem[i_w_addr] <= i_w_data;
    end
  end

  assign o_r_data = r_mem[i_r_addr];

endmodule

// File: rtl/bp_trace_out_buffer.sv
// Buffers 64b trace packets and serializes each as LO then HI 32b word toward the host FIFO.
// Optional BP_TRACE_OUT_BUFFER_DROP_EN: never stall the encoder; discard and count packets while full.
module bp_trace_out_buffer
  import bp_trace_pkg::*;
#(
  parameter int trace_width_p = trace_width_gp,
  parameter int word_width_p  = trace_word_width_gp,
  parameter int els_p         = 16,
  localparam int ptr_w_lp     = $clog2(els_p),
  localparam int cnt_w_lp     = $clog2(els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [trace_width_p-1:0] trace_data_i,
  input  logic                     trace_v_i,
  output logic                     trace_ready_o,
  output logic [word_width_p-1:0]  word_data_o,
  output logic                     word_v_o,
  input  logic                     word_ready_i,
  output logic [cnt_w_lp-1:0]      count_o,
  output logic [15:0]              drop_cnt_o
);

  logic [ptr_w_lp-1:0]      r_wptr;
  logic [ptr_w_lp-1:0]      r_rptr;
  logic [cnt_w_lp-1:0]      r_count;
  bp_trace_word_sel_e       r_state;
  bp_trace_word_sel_e       w_state_n;
  logic [trace_width_p-1:0] w_rd_data;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_xfer;
  logic                     w_pop;

  assign w_full  = (r_count == cnt_w_lp'(els_p));
  assign w_empty = (r_count == '0);

  // Acceptance looks only at the registered count, so a same-cycle pop never frees a slot early.
`ifdef BP_TRACE_OUT_BUFFER_DROP_EN
  logic [15:0] r_drop_cnt;

  assign trace_ready_o = 1'b1;
  assign w_push        = trace_v_i & ~w_full;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_drop_cnt <= '0;
    end else if (trace_v_i && w_full && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = r_drop_cnt;
`else
  assign trace_ready_o = ~w_full;
  assign w_push        = trace_v_i & trace_ready_o;
  assign drop_cnt_o    = 16'h0000;
`endif

  assign word_v_o = ~w_empty;
  assign w_xfer   = word_v_o & word_ready_i;
  assign w_pop    = w_xfer & (r_state == e_trace_hi);
  assign count_o  = r_count;

  bp_trace_out_buffer_mem #(
    .els_p   (els_p),
    .width_p (trace_width_p)
  ) u_mem (
    .i_clk    (clk_i),
    .i_w_v    (w_push),
    .i_w_addr (r_wptr),
    .i_w_data (trace_data_i),
    .i_r_addr (r_rptr),
    .o_r_data (w_rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + ptr_w_lp'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + ptr_w_lp'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_w_lp'(1);
        2'b01:   r_count <= r_count - cnt_w_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= e_trace_lo;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    word_data_o = w_rd_data[word_width_p-1:0];
    case (r_state)
      e_trace_lo: begin
        if (w_xfer) w_state_n = e_trace_hi;
      end
      e_trace_hi: begin
        word_data_o = w_rd_data[trace_width_p-1:word_width_p];
        if (w_xfer) w_state_n = e_trace_lo;
      end
      default: w_state_n = e_trace_lo;
    endcase
  end

endmodule

// File: tb/tb_bp_trace_out_buffer.sv
// Randomized self-checking bench for bp_trace_out_buffer against a packet-queue reference model.
module tb_bp_trace_out_buffer;

  localparam int ELS = 16;
`ifdef BP_TRACE_OUT_BUFFER_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk_i;
  logic        reset_n_i;
  logic [63:0] trace_data_i;
  logic        trace_v_i;
  logic        trace_ready_o;
  logic [31:0] word_data_o;
  logic        word_v_o;
  logic        word_ready_i;
  logic [4:0]  count_o;
  logic [15:0] drop_cnt_o;

  bp_trace_out_buffer #(.trace_width_p(64), .word_width_p(32), .els_p(ELS)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .trace_data_i  (trace_data_i),
    .trace_v_i     (trace_v_i),
    .trace_ready_o (trace_ready_o),
    .word_data_o   (word_data_o),
    .word_v_o      (word_v_o),
    .word_ready_i  (word_ready_i),
    .count_o       (count_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: whole packets in arrival order, plus whether the low half has left.
  logic [63:0] m_q[$];
  bit          m_half;
  int          m_drop;
  logic [63:0] seq;

  function automatic logic [31:0] exp_word();
    logic [63:0] p;
    p = m_q[0];
    return m_half ? p[63:32] : p[31:0];
  endfunction

  function automatic bit exp_ready();
    return DROP_EN ? 1'b1 : (m_q.size() < ELS);
  endfunction

  task automatic advance(input bit v, input logic [63:0] d, input bit rdy);
    bit push, drop, xfer;
    trace_v_i    = v;
    trace_data_i = d;
    word_ready_i = rdy;
    push = v && (m_q.size() < ELS);
    drop = v && (m_q.size() >= ELS) && DROP_EN;
    xfer = rdy && (m_q.size() != 0);
    @(posedge clk_i);
    if (xfer) begin
      if (m_half) begin
        m_q.delete(0);
        m_half = 1'b0;
      end else begin
        m_half = 1'b1;
      end
    end
    if (push) m_q.push_back(d);
    if (drop && m_drop < 65535) m_drop++;
    @(negedge clk_i);
  endtask

  task automatic apply_reset(input int cycles);
    reset_n_i = 1'b0;
    trace_v_i = 1'b1;
    trace_data_i = {$urandom, $urandom};
    word_ready_i = 1'b1;
    for (int i = 0; i < cycles; i++) @(posedge clk_i);
    @(negedge clk_i);
    m_q.delete();
    m_half = 1'b0;
    m_drop = 0;
    reset_n_i = 1'b1;
    trace_v_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * ELS + 8 && m_q.size() != 0; i++) advance(1'b0, 64'h0, 1'b1);
  endtask

  task automatic test_reset();
    apply_reset(3);
    n_checks++;
    if (word_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_word_v: got %b expected 0", word_v_o); end
    n_checks++;
    if (count_o !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    n_checks++;
    if (trace_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", trace_ready_o); end
    n_checks++;
    if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt_o); end
    advance(1'b0, 64'h0, 1'b1);
    n_checks++;
    if (count_o !== 5'd0 || word_v_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_push: count %0d v %b expected 0 0", count_o, word_v_o);
    end
  endtask

  task automatic test_single();
    advance(1'b1, 64'hDEADBEEF_01234567, 1'b1);
    trace_v_i = 1'b0;
    n_checks++;
    if (word_v_o !== 1'b1 || word_data_o !== 32'h01234567 || count_o !== 5'd1) begin
      n_fail++; $display("FAIL single_lo: v %b data %h count %0d expected 1 01234567 1", word_v_o, word_data_o, count_o);
    end
    advance(1'b0, 64'h0, 1'b1);
    n_checks++;
    if (word_v_o !== 1'b1 || word_data_o !== 32'hDEADBEEF || count_o !== 5'd1) begin
      n_fail++; $display("FAIL single_hi: v %b data %h count %0d expected 1 deadbeef 1", word_v_o, word_data_o, count_o);
    end
    advance(1'b0, 64'h0, 1'b1);
    n_checks++;
    if (word_v_o !== 1'b0 || count_o !== 5'd0) begin
      n_fail++; $display("FAIL single_done: v %b count %0d expected 0 0", word_v_o, count_o);
    end
  endtask

  task automatic test_fill();
    logic [63:0] extra;
    for (int i = 0; i < ELS; i++) advance(1'b1, {$urandom, $urandom}, 1'b0);
    n_checks++;
    if (count_o !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d expected 16", count_o); end
    n_checks++;
    if (trace_ready_o !== exp_ready()) begin
      n_fail++; $display("FAIL fill_ready: got %b expected %b", trace_ready_o, exp_ready());
    end
    extra = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) advance(1'b1, extra, 1'b0);
    n_checks++;
    if (count_o !== 5'd16) begin n_fail++; $display("FAIL full_hold_count: got %0d expected 16", count_o); end
    n_checks++;
    if (drop_cnt_o !== 16'(m_drop)) begin
      n_fail++; $display("FAIL full_drop_cnt: got %0d expected %0d", drop_cnt_o, m_drop);
    end
    n_checks++;
    if (trace_ready_o !== exp_ready()) begin
      n_fail++; $display("FAIL full_ready: got %b expected %b", trace_ready_o, exp_ready());
    end
    // Keep the extra packet offered: held upstream, it must enter once a slot frees.
    for (int i = 0; i < 2 * ELS + 4; i++) begin
      advance(1'b1, extra, 1'b1);
      trace_v_i = 1'b0;
      n_checks++;
      if (word_v_o !== (m_q.size() != 0) || count_o !== 5'(m_q.size()) ||
          (m_q.size() != 0 && word_data_o !== exp_word())) begin
        n_fail++; $display("FAIL fill_drain: v %b data %h count %0d expected %b %h %0d",
                           word_v_o, word_data_o, count_o, m_q.size() != 0, exp_word(), m_q.size());
      end
      if (m_q.size() == 0) break;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [63:0] p;
    p = {$urandom, $urandom};
    advance(1'b1, p, 1'b0);
    advance(1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      advance(1'b0, 64'h0, 1'b0);
      n_checks++;
      if (word_v_o !== 1'b1 || word_data_o !== p[63:32] || count_o !== 5'd1) begin
        n_fail++; $display("FAIL bp_hold: v %b data %h count %0d expected 1 %h 1", word_v_o, word_data_o, count_o, p[63:32]);
      end
    end
    advance(1'b0, 64'h0, 1'b1);
    n_checks++;
    if (word_v_o !== 1'b0 || count_o !== 5'd0) begin
      n_fail++; $display("FAIL bp_release: v %b count %0d expected 0 0", word_v_o, count_o);
    end
  endtask

  task automatic test_stream();
    bit v;
    for (int i = 0; i < 8; i++) begin
      advance(1'b1, seq, 1'b0);
      seq++;
    end
    // Push only in HI cycles so every push coincides with a pop.
    for (int i = 0; i < 40; i++) begin
      v = m_half;
      advance(v, seq, 1'b1);
      if (v) seq++;
      n_checks++;
      if (count_o !== 5'd8 || word_v_o !== 1'b1 || word_data_o !== exp_word()) begin
        n_fail++; $display("FAIL stream: count %0d v %b data %h expected 8 1 %h", count_o, word_v_o, word_data_o, exp_word());
      end
    end
    trace_v_i = 1'b0;
    drain();
    n_checks++;
    if (count_o !== 5'd0) begin n_fail++; $display("FAIL stream_drain: count %0d expected 0", count_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      advance(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
      n_checks++;
      if (word_v_o !== (m_q.size() != 0) || count_o !== 5'(m_q.size()) ||
          trace_ready_o !== exp_ready() || drop_cnt_o !== 16'(m_drop) ||
          (m_q.size() != 0 && word_data_o !== exp_word())) begin
        n_fail++; $display("FAIL random[%0d]: v %b data %h count %0d rdy %b drop %0d expected %b %h %0d %b %0d",
                           i, word_v_o, word_data_o, count_o, trace_ready_o, drop_cnt_o,
                           m_q.size() != 0, exp_word(), m_q.size(), exp_ready(), m_drop);
      end
    end
  endtask

  task automatic test_reset_mid();
    advance(1'b1, {$urandom, $urandom}, 1'b0);
    advance(1'b0, 64'h0, 1'b1);
    apply_reset(1);
    trace_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (word_v_o !== 1'b0 || count_o !== 5'd0) begin
        n_fail++; $display("FAIL reset_mid: v %b count %0d expected 0 0", word_v_o, count_o);
      end
      advance(1'b0, 64'h0, 1'b1);
    end
  endtask

  initial begin
    reset_n_i    = 1'b1;
    trace_v_i    = 1'b0;
    trace_data_i = '0;
    word_ready_i = 1'b0;
    m_half       = 1'b0;
    m_drop       = 0;
    seq          = 64'h0000_1000_0000_0000;
    @(negedge clk_i);
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
